exhaustive_equiv_checker: RTL and testbench
===========================================

Name: exhaustive_equiv_checker

Overview:
- Self-contained sweep-and-compare engine for board-level equivalence checking of two combinational implementations with the same N_IN-bit input {A,B,C,D} and 2-bit output {X,Y}.
- Sits upstream of both implementations: drives a shared input vector to them and consumes their outputs.
- Walks every input combination, compares X/Y pairs after a settle window, counts mismatches and latches the first failing vector.
- Results go to LEDs or a status register.

Parameters:
- N_IN, 4, width of the input vector swept (2^N_IN vectors).
- SETTLE_CYC, 1, clock cycles each vector is held before comparison; legal range 0..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request, sampled only in IDLE and DONE.
- vec_o  output  N_IN  vector driven to both implementations; vec_o[N_IN-1] = A, vec_o[0] = D.
- x1_i, y1_i  input  1 each  outputs of implementation 1.
- x2_i, y2_i  input  1 each  outputs of implementation 2.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done = 1; high iff err_cnt = 0.
- err_cnt  output  N_IN+1  number of mismatching vectors; cannot overflow.
- first_err_valid  output  1  at least one mismatch recorded in the current sweep.
- first_err_vec  output  N_IN  vec_o value at the first mismatch.
- mismatch_p  output  1  one-cycle pulse, registered, after each failing CHECK.

Behaviour:
- Reset: all outputs 0; state IDLE. Applies from any state, including mid-sweep; no partial results are kept.
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE or DONE, with start = 1:
  - vec_o <= 0, err_cnt <= 0, first_err_valid <= 0, first_err_vec <= 0, done <= 0, pass <= 0.
  - settle counter <= SETTLE_CYC.
  - Next state is SETTLE, or CHECK when SETTLE_CYC = 0.
- start = 0 in DONE: remain in DONE; results held indefinitely.
- start in SETTLE or CHECK is ignored, with no restart or queueing.
- SETTLE: counter decrements each cycle. Go to CHECK on the edge where counter = 1. vec_o is stable throughout.
- CHECK lasts exactly one cycle, with vec_o unchanged:
  - mismatch = (x1_i ^ x2_i) | (y1_i ^ y2_i), sampled at the closing edge.
  - On mismatch: err_cnt++, mismatch_p <= 1 for the next cycle. If first_err_valid = 0, then first_err_vec <= vec_o and first_err_valid <= 1.
  - If vec_o = all-ones: go to DONE; done <= 1; pass <= (no mismatch in whole sweep, including this vector). vec_o holds all-ones; there is no wrap.
  - Otherwise: vec_o <= vec_o + 1, reload counter, go to SETTLE (or CHECK again when SETTLE_CYC = 0).
- Timing: each vector occupies SETTLE_CYC+1 cycles. done rises 2^N_IN × (SETTLE_CYC+1) cycles after the edge that accepted start.
  - Defaults: 32 cycles.
  - SETTLE_CYC = 0: 16 cycles.
- err_cnt maximum is 2^N_IN (16), which fits N_IN+1 bits, so it never saturates or wraps.
- pass is meaningful only while done = 1; it is forced 0 otherwise.

Test Plan:
- Identical implementations (x2 = x1, y2 = y1), pulse start → busy for 32 cycles, vec_o steps 0..15 with each value held 2 cycles. Then done = 1, pass = 1, err_cnt = 0, first_err_valid = 0, mismatch_p never high.
- Fault injected only at vector 5 (x2 = x1 ^ (vec == 5)) → err_cnt = 1, first_err_vec = 5, first_err_valid = 1, pass = 0. One mismatch_p pulse, in the cycle after the vec_o = 5 CHECK.
- Fault at vectors 3 and 12 on Y only → err_cnt = 2, first_err_vec = 3 (not overwritten by 12), pass = 0.
- Fully inverted X (x2 = ~x1) → err_cnt = 16, first_err_vec = 0, pass = 0.
- rst pulsed while vec_o = 7; start pulsed mid-sweep → start causes no restart. After reset, next cycle all outputs are 0 and state is IDLE. A fresh start then sweeps from 0 to a correct result.
- After a failing sweep in DONE, pulse start with identical implementations → results cleared on the start edge, new sweep gives pass = 1. SETTLE_CYC = 0 build: done rises exactly 16 cycles after start.

Source files
------------

// File: rtl/exhaustive_equiv_checker.sv
// Sweep-and-compare engine: drives every N_IN-bit vector to two combinational
// implementations, compares their {X,Y} outputs and reports mismatch statistics.
module exhaustive_equiv_checker #(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_o,
  input  logic            x1_i,
  input  logic            y1_i,
  input  logic            x2_i,
  input  logic            y2_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec,
  output logic            mismatch_p
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYC);
  // With no settle window each vector goes straight to its compare cycle.
  localparam state_t          STEP_STATE  = (SETTLE_CYC == 0) ? CHECK : SETTLE;

  state_t          state;
  logic [3:0]      settle_cnt;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  assign mismatch = (x1_i ^ x2_i) | (y1_i ^ y2_i);
  assign err_next = err_cnt + {{N_IN{1'b0}}, mismatch};

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      vec_o           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      mismatch_p      <= 1'b0;
    end else begin
      mismatch_p <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_o           <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            settle_cnt      <= SETTLE_LOAD;
            state           <= STEP_STATE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) state <= CHECK;
        end
        CHECK: begin
          err_cnt <= err_next;
          if (mismatch) begin
            mismatch_p <= 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= vec_o;
            end
          end
          // Last vector ends the sweep; vec_o stays at all-ones rather than wrapping.
          if (vec_o == VEC_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec_o      <= vec_o + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= STEP_STATE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Directed bench: table of sweep scenarios with fault patterns, plus reset,
// restart and zero-settle timing sequences.
module tb_exhaustive_equiv_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start0;
  logic [1:0] mode;

  logic [3:0] vec, first_err_vec;
  logic [4:0] err_cnt;
  logic       x1, y1, x2, y2;
  logic       busy, done, pass, first_err_valid, mismatch_p;

  logic [3:0] vec0, first_err_vec0;
  logic [4:0] err_cnt0;
  logic       busy0, done0, pass0, first_err_valid0, mismatch_p0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic fx(input logic [3:0] v);
    return ^v;
  endfunction

  function automatic logic fy(input logic [3:0] v);
    return (v[3] & v[0]) | v[1];
  endfunction

  // mode 0: identical, 1: X fault at 5, 2: Y fault at 3 and 12, 3: X inverted
  assign x1 = fx(vec);
  assign y1 = fy(vec);
  assign x2 = fx(vec) ^ ((mode == 2'd1) && (vec == 4'd5)) ^ (mode == 2'd3);
  assign y2 = fy(vec) ^ ((mode == 2'd2) && ((vec == 4'd3) || (vec == 4'd12)));

  exhaustive_equiv_checker #(.N_IN(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_o(vec),
    .x1_i(x1), .y1_i(y1), .x2_i(x2), .y2_i(y2),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec),
    .mismatch_p(mismatch_p)
  );

  exhaustive_equiv_checker #(.N_IN(4), .SETTLE_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_o(vec0),
    .x1_i(fx(vec0)), .y1_i(fy(vec0)), .x2_i(fx(vec0)), .y2_i(fy(vec0)),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0),
    .first_err_valid(first_err_valid0), .first_err_vec(first_err_vec0),
    .mismatch_p(mismatch_p0)
  );

  typedef struct {
    logic [1:0] mode;
    int         exp_err;
    int         exp_first_vec;
    logic       exp_first_valid;
    logic       exp_pass;
    int         exp_pulses;
  } sweep_t;

  sweep_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_sweep(input sweep_t t, input int idx);
    int         c;
    int         pulses;
    int         first_pv;
    int         exp_vec;
    logic       seq_ok;
    logic       busy_ok;
    logic [3:0] prev;
    logic [4:0] held_err;
    mode = t.mode;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check($sformatf("sweep%0d_clear_on_start", idx),
          {23'd0, done, pass, first_err_valid, err_cnt}, 32'd0);
    c = 0; pulses = 0; first_pv = -1;
    seq_ok  = (vec === 4'd0);
    busy_ok = (busy === 1'b1);
    prev    = vec;
    while (done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
      if (mismatch_p === 1'b1) begin
        pulses++;
        if (first_pv < 0) first_pv = int'(prev);
      end
      exp_vec = (c / 2 > 15) ? 15 : c / 2;
      if (vec !== 4'(exp_vec)) seq_ok = 1'b0;
      if (busy !== (c < 32)) busy_ok = 1'b0;
      prev = vec;
    end
    check($sformatf("sweep%0d_cycles", idx), c, 32);
    check($sformatf("sweep%0d_vec_seq", idx), {31'd0, seq_ok}, 32'd1);
    check($sformatf("sweep%0d_busy", idx), {31'd0, busy_ok}, 32'd1);
    check($sformatf("sweep%0d_err_cnt", idx), {27'd0, err_cnt}, t.exp_err);
    check($sformatf("sweep%0d_first_err_vec", idx), {28'd0, first_err_vec}, t.exp_first_vec);
    check($sformatf("sweep%0d_first_err_valid", idx), {31'd0, first_err_valid}, {31'd0, t.exp_first_valid});
    check($sformatf("sweep%0d_pass", idx), {31'd0, pass}, {31'd0, t.exp_pass});
    check($sformatf("sweep%0d_pulses", idx), pulses, t.exp_pulses);
    if (t.exp_pulses > 0)
      check($sformatf("sweep%0d_first_pulse_vec", idx), first_pv, t.exp_first_vec);
    held_err = err_cnt;
    repeat (3) @(negedge clk);
    check($sformatf("sweep%0d_done_hold", idx), {26'd0, done, err_cnt}, {26'd0, 1'b1, t.exp_err[4:0]});
    check($sformatf("sweep%0d_hold_vec", idx), {27'd0, held_err == err_cnt, vec}, {27'd0, 1'b1, 4'hf});
  endtask

  initial begin
    int c;
    tbl[0] = '{2'd0, 0,  0, 1'b0, 1'b1, 0};
    tbl[1] = '{2'd1, 1,  5, 1'b1, 1'b0, 1};
    tbl[2] = '{2'd2, 2,  3, 1'b1, 1'b0, 2};
    tbl[3] = '{2'd3, 16, 0, 1'b1, 1'b0, 16};
    tbl[4] = '{2'd0, 0,  0, 1'b0, 1'b1, 0};

    rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {17'd0, vec, busy, done, pass, err_cnt, first_err_valid, first_err_vec, mismatch_p}, 32'd0);
    rst = 1'b0;

    // Entry 4 follows the failing inverted sweep: restart straight from DONE.
    for (int i = 0; i < 5; i++) run_sweep(tbl[i], i);

    // Mid-sweep start is ignored, then a synchronous reset abandons the sweep.
    mode = 2'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0;
    while (vec !== 4'd7 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("reach_vec7", {31'd0, c < 100}, 32'd1);
    check("pre_reset_err_cnt", {27'd0, err_cnt}, 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("no_restart", {31'd0, (vec >= 4'd7) && busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_reset_outputs",
          {17'd0, vec, busy, done, pass, err_cnt, first_err_valid, first_err_vec, mismatch_p}, 32'd0);
    repeat (2) @(negedge clk);
    check("idle_after_reset", {27'd0, busy, vec}, 32'd0);
    run_sweep(tbl[0], 5);

    // Zero settle window: one cycle per vector.
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    c = 0;
    while (done0 !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("settle0_cycles", c, 16);
    check("settle0_result", {26'd0, pass0, err_cnt0}, {26'd0, 1'b1, 5'd0});
    check("settle0_vec_last", {28'd0, vec0}, 32'hf);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
